pipeline_ctrl: RTL and testbench

Central pipeline controller for the five-stage core. It turns per-stage stall requests into the six-bit `stall` vector consumed by the pc register and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It sequences exception flushes: it latches the handler address, drives a one-cycle `flush`, then enforces a short refill shadow. It also keeps stall and flush statistics and a stall watchdog.

---
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central controller for the five-stage core. It has three jobs:
//   * Priority-encode the per-stage stall requests into a contiguous
//     freeze vector for the pc register and the inter-stage registers.
//   * Sequence exception flushes: capture the handler address, pulse
//     `flush` for one cycle, then ignore further flush requests for a
//     short refill shadow while wrong-path bubbles drain.
//   * Keep saturating stall/flush statistics and a sticky watchdog that
//     trips when the front end stays frozen too long.
//
// Parameters
//   REFILL_CYCLES  cycles after a flush during which flush_req is ignored
//   TIMEOUT        consecutive stall[0] cycles that set stall_timeout
//   CNT_W          width of the statistics counters
//
// Ports
//   clk                in   clock, rising edge
//   rst                in   asynchronous active-high reset
//   stallreq_from_if   in   instruction bus wait
//   stallreq_from_id   in   load-use / operand hazard
//   stallreq_from_ex   in   multi-cycle op busy
//   stallreq_from_mem  in   data bus wait
//   flush_req          in   exception committed in mem stage
//   flush_pc   [31:0]  in   handler address accompanying flush_req
//   clr_stat           in   synchronous clear of statistics and watchdog
//   stall      [5:0]   out  bit0 pc .. bit5 wb, 1 = hold
//   flush              out  clear inter-stage registers, load new_pc
//   new_pc     [31:0]  out  fetch redirect address, valid with flush
//   stall_cnt          out  saturating count of cycles with stall[0]=1
//   flush_cnt          out  saturating count of flushes issued
//   stall_timeout      out  sticky watchdog flag
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned REFILL_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    input  logic             clr_stat,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam int unsigned    RW          = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);
    localparam logic [RW-1:0]  REFILL_INIT = RW'(REFILL_CYCLES);
    localparam logic [16:0]    TIMEOUT_W   = 17'(TIMEOUT);

    state_t           r_state;
    logic [RW-1:0]    r_refill;
    logic             r_flush;
    logic [31:0]      r_new_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [15:0]      r_consec;
    logic             r_timeout;

    logic [5:0]       w_stall_enc;
    logic             w_stall0;
    logic [16:0]      w_consec_next;

    // Each stage stalls everything upstream of it, so every encoding is a
    // contiguous run of ones from bit0; an if-only stall freezes pc and if
    // while if_id injects a bubble into id.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_stall_enc = 6'b000000;
        if (stallreq_from_mem)     w_stall_enc = 6'b011111;
        else if (stallreq_from_ex) w_stall_enc = 6'b001111;
        else if (stallreq_from_id) w_stall_enc = 6'b000111;
        else if (stallreq_from_if) w_stall_enc = 6'b000011;
    end

    // The flush cycle clears every register anyway, so holding any of them
    // would only fight the clear; reset is included so nothing is frozen
    // while the core is being initialised.
    assign stall    = (rst || r_flush) ? 6'b000000 : w_stall_enc;
    assign w_stall0 = stall[0];

    // -------------------------------------------------------------------------
    // Flush sequencer. r_flush is high exactly while the FSM sits in FLUSH,
    // so the output is registered and also drops asynchronously on reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_refill <= '0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            case (r_state)
                RUN: begin
                    r_flush <= 1'b0;
                    if (flush_req) begin
                        r_new_pc <= flush_pc;
                        r_flush  <= 1'b1;
                        r_state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_flush  <= 1'b0;
                    r_refill <= REFILL_INIT;
                    if (REFILL_CYCLES == 0) r_state <= RUN;
                    else                    r_state <= REFILL;
                end
                REFILL: begin
                    // Requests here come from bubbles or wrong-path stages
                    // and are dropped.
                    r_flush  <= 1'b0;
                    r_refill <= r_refill - RW'(1);
                    if (r_refill <= RW'(1)) r_state <= RUN;
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Statistics and watchdog. clr_stat takes precedence over any increment
    // on the same edge.
    // -------------------------------------------------------------------------
    assign w_consec_next = {1'b0, r_consec} + 17'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_consec    <= 16'h0;
            r_timeout   <= 1'b0;
        end else if (clr_stat) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_consec    <= 16'h0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_stall0 && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            // Counted on the edge that leaves FLUSH.
            if (r_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_stall0) begin
                if (r_consec != 16'hFFFF) r_consec <= w_consec_next[15:0];
                // Compare the post-increment value so the flag rises on the
                // same edge the run length reaches TIMEOUT.
                if (w_consec_next >= TIMEOUT_W) r_timeout <= 1'b1;
            end else begin
                r_consec <= 16'h0;
            end
        end
    end

    assign flush         = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl with REFILL_CYCLES=2, TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; registered outputs are read
// there too, and combinational outputs 1 unit after an input change.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int unsigned REFILL_CYCLES = 2;
    localparam int unsigned TIMEOUT       = 8;
    localparam int unsigned CNT_W         = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_from_if;
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic             clr_stat;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ctrl #(
        .REFILL_CYCLES (REFILL_CYCLES),
        .TIMEOUT       (TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .flush_req         (flush_req),
        .flush_pc          (flush_pc),
        .clr_stat          (clr_stat),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
        .stall_timeout     (stall_timeout)
    );

    always #5 clk = ~clk;

    // Request vector packing: {mem, ex, id, if}.
    typedef struct {
        logic [3:0] req;
        logic [5:0] exp_stall;
    } stall_vec_t;

    stall_vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        stallreq_from_mem = r[3];
        stallreq_from_ex  = r[2];
        stallreq_from_id  = r[1];
        stallreq_from_if  = r[0];
    endtask

    task automatic pulse_clr();
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
    endtask

    logic [5:0] flush_seen;

    initial begin
        vecs[0] = '{4'b1111, 6'b011111};
        vecs[1] = '{4'b0111, 6'b001111};
        vecs[2] = '{4'b0011, 6'b000111};
        vecs[3] = '{4'b0001, 6'b000011};
        vecs[4] = '{4'b0000, 6'b000000};
        vecs[5] = '{4'b1001, 6'b011111};
        vecs[6] = '{4'b0100, 6'b001111};
        vecs[7] = '{4'b0010, 6'b000111};
        vecs[8] = '{4'b0101, 6'b001111};
        vecs[9] = '{4'b1000, 6'b011111};

        rst = 1'b1;
        set_req(4'b1000);
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        clr_stat  = 1'b0;

        // ---- reset: stall forced to zero even with a mem request ----
        #12;
        check("stall_in_reset", 64'(stall), 64'(6'b000000));
        check("flush_in_reset", 64'(flush), 64'h0);
        set_req(4'b0000);
        step();
        rst = 1'b0;

        // ---- ten idle cycles after release ----
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_all_zero",
                  {26'h0, stall, flush, new_pc, stall_timeout, 4'h0},
                  64'h0);
        end
        check("idle_stall_cnt", 64'(stall_cnt), 64'h0);
        check("idle_flush_cnt", 64'(flush_cnt), 64'h0);

        // ---- stall encoding table, visible the same cycle ----
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].req);
            #1;
            check($sformatf("stall_vec%0d", i), 64'(stall), 64'(vecs[i].exp_stall));
            step();
        end
        set_req(4'b0000);
        pulse_clr();
        check("clr_stall_cnt", 64'(stall_cnt), 64'h0);

        // ---- single flush with a concurrent id stall ----
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0040;
        set_req(4'b0010);
        #1;
        check("stall_with_flush_req", 64'(stall), 64'(6'b000111));
        check("flush_not_yet", 64'(flush), 64'h0);
        step();
        check("flush_pulse", 64'(flush), 64'h1);
        check("stall_forced_in_flush", 64'(stall), 64'h0);
        check("new_pc_captured", 64'(new_pc), 64'h40);
        flush_req = 1'b0;
        flush_pc  = 32'h0000_1234;
        set_req(4'b0000);
        step();
        check("flush_one_cycle", 64'(flush), 64'h0);
        check("flush_cnt_1", 64'(flush_cnt), 64'h1);
        check("new_pc_holds", 64'(new_pc), 64'h40);
        // drain the refill shadow
        step();
        step();
        step();
        pulse_clr();

        // ---- flush_req held 6 cycles: flushes 4 edges apart ----
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0040;
        flush_seen = 6'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            flush_seen[i] = flush;
            if (i == 0) flush_pc = 32'h0000_0080;
            if (i == 2) check("new_pc_ignores_refill", 64'(new_pc), 64'h40);
            if (i == 4) check("new_pc_second", 64'(new_pc), 64'h80);
        end
        flush_req = 1'b0;
        check("flush_pattern", 64'(flush_seen), 64'(6'b010001));
        check("flush_cnt_2", 64'(flush_cnt), 64'h2);
        step();
        step();
        step();

        // ---- watchdog ----
        pulse_clr();
        set_req(4'b0100);
        for (int i = 0; i < 7; i++) step();
        check("timeout_before", 64'(stall_timeout), 64'h0);
        check("stall_cnt_7", 64'(stall_cnt), 64'h7);
        step();
        check("timeout_rises", 64'(stall_timeout), 64'h1);
        check("stall_cnt_8", 64'(stall_cnt), 64'h8);
        set_req(4'b0000);
        step();
        step();
        check("timeout_sticky", 64'(stall_timeout), 64'h1);
        check("stall_cnt_held", 64'(stall_cnt), 64'h8);
        set_req(4'b0100);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        set_req(4'b0000);
        check("clr_timeout", 64'(stall_timeout), 64'h0);
        check("clr_wins_stall_cnt", 64'(stall_cnt), 64'h0);
        check("clr_flush_cnt", 64'(flush_cnt), 64'h0);
        step();

        // ---- asynchronous reset during FLUSH ----
        flush_req = 1'b1;
        flush_pc  = 32'h0000_00C0;
        step();
        flush_req = 1'b0;
        check("flush_before_rst", 64'(flush), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        check("flush_async_drop", 64'(flush), 64'h0);
        check("new_pc_async_clear", 64'(new_pc), 64'h0);
        step();
        rst = 1'b0;
        step();
        check("new_pc_after_rst", 64'(new_pc), 64'h0);
        check("flush_after_rst", 64'(flush), 64'h0);
        // state must be RUN: a new request flushes on the very next edge
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0100;
        step();
        flush_req = 1'b0;
        check("run_after_rst", 64'(flush), 64'h1);
        check("new_pc_after_rst_flush", 64'(new_pc), 64'h100);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
